// File: rtl/relm_pkg.sv
// Shared constants for the relm push-channel blocks: default widths, requester
// count limits and helpers for the derived slice and pointer widths.
package relm_pkg;

    localparam int RELM_WD_DEF      = 32;
    localparam int RELM_N_DEF       = 4;
    localparam int RELM_N_MIN       = 2;
    localparam int RELM_N_MAX       = 8;
    localparam int RELM_SLICE_W_DEF = RELM_WD_DEF + 1;

    // A push channel carries a valid bit above the data word.
    function automatic int relm_slice_w(input int wd);
        return wd + 1;
    endfunction

    function automatic int relm_ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/relm_rr_pick.sv
// Circular priority pick: lowest-index valid bit scanning upward from ptr,
// wrapping at N. Purely combinational.
module relm_rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant,
    output logic          any
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest valid one wins.
    always_comb begin
        grant = '0;
        sum   = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N))
                sum = sum - (PW+1)'(N);
            idx = sum[PW-1:0];
            if (valid[idx])
                grant = idx;
        end
        any = |valid;
    end

endmodule

// File: rtl/relm_push_arb.sv
// N-to-1 round-robin push arbiter with a single output register; requesters
// that are not accepted see retry and repeat their push.
module relm_push_arb
    import relm_pkg::*;
#(
    parameter int WD = RELM_WD_DEF,
    parameter int N  = RELM_N_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*(WD+1)-1:0] req_d,
    output logic [N-1:0]       req_retry,
    output logic [WD:0]        push_d,
    input  logic               push_retry
);

    localparam int SW = relm_slice_w(WD);
    localparam int PW = relm_ptr_w(N);

    typedef struct packed {
        logic          vld;
        logic [WD-1:0] data;
    } push_t;

    logic [N-1:0]         req_vld;
    logic [N-1:0][WD-1:0] req_data;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign req_vld[i]  = req_d[i*SW + WD];
        assign req_data[i] = req_d[i*SW +: WD];
    end

    push_t         out_q;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] grant;
    logic [PW-1:0] ptr_nxt;
    logic          any_vld;
    logic          slot_free;
    logic          accept;

    relm_rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .valid (req_vld),
        .ptr   (ptr_q),
        .grant (grant),
        .any   (any_vld)
    );

    // A slot frees either because OUT is empty or because it is popped this
    // cycle, which lets a new push land behind a departing one.
    assign slot_free = !out_q.vld || !push_retry;
    assign accept    = slot_free && any_vld && !rst;
    assign ptr_nxt   = (grant == PW'(N - 1)) ? '0 : grant + PW'(1);

    for (genvar i = 0; i < N; i++) begin : g_retry
        assign req_retry[i] = req_vld[i] && !(accept && grant == PW'(i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            ptr_q <= '0;
        end else if (slot_free) begin
            if (any_vld) begin
                out_q <= '{vld: 1'b1, data: req_data[grant]};
                ptr_q <= ptr_nxt;
            end else begin
                out_q.vld <= 1'b0;
            end
        end
    end

    assign push_d = out_q;

    a_ptr_range: assert property (@(posedge clk) disable iff (rst)
        {1'b0, ptr_q} < (PW+1)'(N));
    a_one_accept: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_vld & ~req_retry));

endmodule

// File: doc/relm_push_arb.md
RELM_PUSH_ARB -- requirements
Module: relm_push_arb

Interface
REQ-001 Parameter WD, default 32: data width of one push channel (channel bus is WD+1 bits).
REQ-002 Parameter N, default 4: number of requester channels, 2..8.
REQ-003 Port clk  input  1: sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port req_d  input  N*(WD+1): requester i occupies slice [i*(WD+1)+:WD+1]; bit WD = push valid, bits [WD-1:0] = data.
REQ-006 Port req_retry  output  N: bit i high = requester i's push this cycle not accepted; requester holds and repeats.
REQ-007 Port push_d  output  WD+1: downstream push channel; bit WD = valid, [WD-1:0] = data.
REQ-008 Port push_retry  input  1: downstream refused the push_d presented this cycle.

Function
REQ-009 The block shall hold one output register OUT (valid + data) driving push_d directly.
REQ-010 Slot free shall be defined as OUT.valid==0 or push_retry==0.
REQ-011 Grant shall be the lowest-index valid requester scanning circularly from round-robin pointer PTR (width clog2(N)).
REQ-012 req_retry[i] shall be combinational: high iff req valid[i] and not (i==grant and slot free); invalid requesters shall see req_retry[i]=0.
REQ-013 On a cycle with slot free and any valid requester, OUT shall load {1, data of grant} at the next edge (latency one cycle from acceptance to push_d).
REQ-014 On slot free with no valid requester, OUT.valid shall clear to 0 at the next edge; OUT.data shall hold.
REQ-015 While OUT.valid==1 and push_retry==1, OUT shall hold unchanged and every valid requester shall see retry.
REQ-016 After an acceptance PTR shall become (grant+1) mod N; PTR shall be unchanged on cycles without acceptance.
REQ-017 Wrap-around: grant N-1 shall set PTR=0; N non-power-of-two shall never produce PTR>=N.
REQ-018 At most one requester shall be accepted per cycle; no push shall be duplicated or dropped.
REQ-019 A continuously valid requester shall be accepted within N slot-free cycles (starvation-free).
REQ-020 Sustained throughput shall be one push per cycle while push_retry stays 0.
REQ-021 Simultaneous pop of OUT (push_retry=0) and acceptance of a new push in the same cycle shall be allowed.

Reset
REQ-022 While rst high: OUT.valid=0, OUT.data=0, PTR=0, push_d=0.
REQ-023 While rst high, req_retry[i] shall equal req valid[i] (nothing accepted).
REQ-024 Reset asserted mid-transfer shall discard OUT contents; the pending requester is not acknowledged and repeats after release.
REQ-025 First acceptance shall be possible in the first clock edge after rst deasserts.

Structure
REQ-026 WD default, N limits and the channel-slice width (WD+1) shall be constants in the shared relm package.
REQ-027 Circular priority selection shall be a combinational sub-module relm_rr_pick (inputs valid vector, PTR; outputs grant index, any-valid).
REQ-028 Total RTL shall be 120-400 lines; no memories, no additional clocks.

Verification
REQ-029 N=4, PTR=0, all four valid with data 0xA0..0xA3, push_retry=0 -> push_d data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, PTR returns to 0.
REQ-030 Only requester 2 valid, data 0x55, push_retry high 3 cycles after first push -> push_d holds {1,0x55} 4 cycles, req_retry[2]=1 during hold, one acceptance only.
REQ-031 Requesters 1 and 3 valid continuously, PTR=2 -> order 3,1,3,1; req_retry toggles per grant; no gaps in push_d.valid.
REQ-032 rst asserted while OUT={1,0x77}, push_retry=1 -> push_d=0 asynchronously, PTR=0, requester retried and re-sent after release.
REQ-033 N=3 with requester 2 granted -> PTR=0 next; random traffic with random push_retry for 10000 cycles -> scoreboard shows every accepted word delivered once, in acceptance order.
